clock_count_controller: RTL and testbench
=========================================

Name: clock_count_controller

Overview:
- Sequences the seconds (mod-60), minutes (mod-60) and hours (mod-24) time counters, and the alarm minutes/hours counters, of the alarm clock.
- Generates each counter's en and updown from the 1 Hz tick, the counter-value feedback and the user buttons.
- Modes: normal timekeeping, and four set modes (time hour, time minute, alarm hour, alarm minute).
- Sits between the button debouncers/tick divider and the counter instances.

Parameters:
- SEC_MAX, 59, terminal value of the seconds counter
- MIN_MAX, 59, terminal value of the minutes counter
- TIMEOUT_TICKS, 30, number of 1 Hz ticks with no button activity before a set mode auto-exits (used only with the optional feature)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- tick_1hz  input  1  one-clk pulse per second
- btn_mode  input  1  debounced one-clk pulse; advances mode
- btn_up  input  1  debounced one-clk pulse; increment in set modes
- btn_down  input  1  debounced one-clk pulse; decrement in set modes
- sec_count  input  6  current seconds counter value
- min_count  input  6  current minutes counter value
- sec_en  output  1  seconds counter enable
- min_en  output  1  minutes counter enable
- hr_en  output  1  hours counter enable
- alm_min_en  output  1  alarm minutes counter enable
- alm_hr_en  output  1  alarm hours counter enable
- updown  output  1  count direction shared by all counters; 1 = up, 0 = down
- sec_clr  output  1  one-clk pulse that clears the seconds counter
- mode  output  3  current state encoding, for display and blink logic

Behaviour:
- All outputs are registered.
- Reset values: mode = RUN (0); all enables = 0; sec_clr = 0; updown = 1.
- Asynchronous reset mid-operation aborts any set mode immediately and returns to RUN.
- States and encodings: RUN = 0, SET_HR = 1, SET_MIN = 2, SET_AHR = 3, SET_AMIN = 4. Encodings 5 to 7 are illegal and go to RUN on the next clk.
- btn_mode transitions: RUN -> SET_HR -> SET_MIN -> SET_AHR -> SET_AMIN -> RUN. One step per pulse; the transition takes effect on the clk edge that samples the pulse.
- Leaving SET_MIN on btn_mode produces sec_clr = 1 for exactly one clk, so seconds restart at 00.
- RUN, on the edge sampling tick_1hz = 1:
  - next cycle, sec_en = 1 for one clk;
  - min_en = 1 in that same cycle iff sampled sec_count == SEC_MAX;
  - hr_en = 1 in that same cycle iff sec_count == SEC_MAX and min_count == MIN_MAX.
  - updown is held at 1 throughout RUN.
  - Latency from tick to enable is 1 clk.
  - Wrap of each counter is left to the counter itself; this block only carries.
- Set modes, on the edge sampling exactly one of btn_up or btn_down:
  - next cycle, the target enable = 1 for one clk;
  - updown = 1 for up, 0 for down;
  - targets: SET_HR -> hr_en, SET_MIN -> min_en, SET_AHR -> alm_hr_en, SET_AMIN -> alm_min_en.
- In set modes, tick_1hz is ignored for counting: the time counters are frozen.
- btn_up and btn_down in the same cycle: no enable is issued; updown keeps its previous value.
- btn_mode together with btn_up/btn_down in the same cycle: the mode change wins and no enable is issued.
- updown holds its last value between pulses. It returns to 1 on the clk edge that enters RUN.
- Never more than one set-mode enable active in a cycle. Enables are never asserted for 2 consecutive clks from a single input pulse.

Optional Feature:
- Macro: SET_TIMEOUT_EN.
- Defined:
  - an inactivity counter (width = clog2(TIMEOUT_TICKS + 1)) clears on entry to any set mode and on any btn_up, btn_down or btn_mode pulse;
  - it increments on tick_1hz while in a set mode;
  - when it reaches TIMEOUT_TICKS, the FSM returns to RUN on the next clk, with no sec_clr;
  - the counter is held at 0 in RUN and by reset.
- Not defined: set modes persist until btn_mode. No counter logic is synthesised.

Test Plan:
- Reset asserted mid-SET_MIN, asynchronously between clk edges -> mode = 0, all enables 0, updown = 1 immediately; RUN resumes counting on the next tick.
- RUN, sec_count = 59, min_count = 59, tick_1hz pulse -> the following clk has sec_en = min_en = hr_en = 1, updown = 1, each for exactly one clk.
- RUN, sec_count = 58, tick -> only sec_en pulses. sec_count = 59, min_count = 12 -> sec_en and min_en pulse, hr_en stays 0.
- btn_mode x1 then btn_down x3 -> mode = 1; three hr_en pulses with updown = 0; sec_en stays 0 across intervening ticks.
- In SET_MIN: btn_up and btn_down in the same clk -> no enable. btn_mode -> mode = 2 advances to 3 with one sec_clr pulse.
- With SET_TIMEOUT_EN defined and TIMEOUT_TICKS = 3: enter SET_AHR, then 3 ticks with no buttons -> mode = 0 one clk after the third tick, sec_clr = 0. Without the macro, mode remains 3.

Source files
------------

// File: rtl/clock_count_controller.sv
// rtl/clock_count_controller.sv - mode FSM and enable/direction sequencing for the alarm clock counters
// Optional inactivity auto-exit from set modes is built when SET_TIMEOUT_EN is defined.
module clock_count_controller #(
    parameter int SEC_MAX       = 59,
    parameter int MIN_MAX       = 59,
    parameter int TIMEOUT_TICKS = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [5:0] sec_count,
    input  logic [5:0] min_count,
    output logic       sec_en,
    output logic       min_en,
    output logic       hr_en,
    output logic       alm_min_en,
    output logic       alm_hr_en,
    output logic       updown,
    output logic       sec_clr,
    output logic [2:0] mode
);

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_HR   = 3'd1,
        SET_MIN  = 3'd2,
        SET_AHR  = 3'd3,
        SET_AMIN = 3'd4
    } state_t;

    state_t state, state_next;
    logic   sec_en_next, min_en_next, hr_en_next, alm_min_en_next, alm_hr_en_next;
    logic   updown_next, sec_clr_next;
    logic   timeout_hit;
    logic   sec_at_max, min_at_max;

    assign sec_at_max = (sec_count == 6'(SEC_MAX));
    assign min_at_max = (min_count == 6'(MIN_MAX));

`ifdef SET_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    logic [TW-1:0] idle_cnt;

    assign timeout_hit = (idle_cnt == TW'(TIMEOUT_TICKS));

    // Idle counter lives only while we stay in a set mode; any button restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (state == RUN || state_next == RUN || state > SET_AMIN) begin
            idle_cnt <= '0;
        end else if (btn_mode || btn_up || btn_down) begin
            idle_cnt <= '0;
        end else if (tick_1hz && !timeout_hit) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    // The timeout length only matters in the timeout build; here this folds to 0.
    assign timeout_hit = (TIMEOUT_TICKS < 0);
`endif

    always_comb begin
        state_next      = state;
        sec_en_next     = 1'b0;
        min_en_next     = 1'b0;
        hr_en_next      = 1'b0;
        alm_min_en_next = 1'b0;
        alm_hr_en_next  = 1'b0;
        sec_clr_next    = 1'b0;
        updown_next     = updown;
        case (state)
            RUN: begin
                updown_next = 1'b1;
                if (btn_mode) state_next = SET_HR;
                // Time keeps counting on the edge that leaves RUN so no second is lost.
                if (tick_1hz) begin
                    sec_en_next = 1'b1;
                    min_en_next = sec_at_max;
                    hr_en_next  = sec_at_max && min_at_max;
                end
            end
            SET_HR, SET_MIN, SET_AHR, SET_AMIN: begin
                if (btn_mode) begin
                    case (state)
                        SET_HR:  state_next = SET_MIN;
                        SET_MIN: state_next = SET_AHR;
                        SET_AHR: state_next = SET_AMIN;
                        default: state_next = RUN;
                    endcase
                    sec_clr_next = (state == SET_MIN);
                    if (state == SET_AMIN) updown_next = 1'b1;
                end else if (timeout_hit) begin
                    state_next  = RUN;
                    updown_next = 1'b1;
                end else if (btn_up ^ btn_down) begin
                    updown_next = btn_up;
                    case (state)
                        SET_HR:  hr_en_next      = 1'b1;
                        SET_MIN: min_en_next     = 1'b1;
                        SET_AHR: alm_hr_en_next  = 1'b1;
                        default: alm_min_en_next = 1'b1;
                    endcase
                end
            end
            default: begin
                state_next  = RUN;
                updown_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            sec_en     <= 1'b0;
            min_en     <= 1'b0;
            hr_en      <= 1'b0;
            alm_min_en <= 1'b0;
            alm_hr_en  <= 1'b0;
            sec_clr    <= 1'b0;
            updown     <= 1'b1;
        end else begin
            state      <= state_next;
            sec_en     <= sec_en_next;
            min_en     <= min_en_next;
            hr_en      <= hr_en_next;
            alm_min_en <= alm_min_en_next;
            alm_hr_en  <= alm_hr_en_next;
            sec_clr    <= sec_clr_next;
            updown     <= updown_next;
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_clock_count_controller.sv
// tb/tb_clock_count_controller.sv - self-checking bench with a behavioural model for clock_count_controller
module tb_clock_count_controller;

    localparam int TMO = 3;
`ifdef SET_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0, btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic [5:0] sec_count = 6'd0, min_count = 6'd0;
    logic       sec_en, min_en, hr_en, alm_min_en, alm_hr_en, updown, sec_clr;
    logic [2:0] mode;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_on   = 1'b0;

    clock_count_controller #(.SEC_MAX(59), .MIN_MAX(59), .TIMEOUT_TICKS(TMO)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .btn_mode(btn_mode),
        .btn_up(btn_up), .btn_down(btn_down), .sec_count(sec_count), .min_count(min_count),
        .sec_en(sec_en), .min_en(min_en), .hr_en(hr_en), .alm_min_en(alm_min_en),
        .alm_hr_en(alm_hr_en), .updown(updown), .sec_clr(sec_clr), .mode(mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: expected outputs for the cycle following each edge.
    // en index: 0 sec, 1 min, 2 hr, 3 alarm hr, 4 alarm min
    int m_mode;
    bit m_en[5];
    bit m_up, m_clr;
    int m_idle;
    int target_of[5] = '{-1, 2, 1, 3, 4};

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_up = 1; m_clr = 0; m_idle = 0;
            foreach (m_en[i]) m_en[i] = 0;
        end else begin
            int  nmode;
            bit  any_btn, hit;
            nmode   = m_mode;
            any_btn = btn_mode || btn_up || btn_down;
            hit     = TMO_ON && (m_idle == TMO);
            foreach (m_en[i]) m_en[i] = 0;
            m_clr = 0;
            if (m_mode == 0) begin
                m_up = 1;
                if (btn_mode) nmode = 1;
                if (tick_1hz) begin
                    m_en[0] = 1;
                    m_en[1] = (sec_count == 59);
                    m_en[2] = (sec_count == 59) && (min_count == 59);
                end
            end else if (btn_mode) begin
                nmode = (m_mode + 1) % 5;
                m_clr = (m_mode == 2);
                if (nmode == 0) m_up = 1;
            end else if (hit) begin
                nmode = 0;
                m_up  = 1;
            end else if (btn_up != btn_down) begin
                m_up = btn_up;
                m_en[target_of[m_mode]] = 1;
            end
            if (m_mode == 0 || nmode == 0 || any_btn) m_idle = 0;
            else if (tick_1hz) m_idle = m_idle + 1;
            m_mode = nmode;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("mode", int'(mode), m_mode);
            check("sec_en", int'(sec_en), int'(m_en[0]));
            check("min_en", int'(min_en), int'(m_en[1]));
            check("hr_en", int'(hr_en), int'(m_en[2]));
            check("alm_hr_en", int'(alm_hr_en), int'(m_en[3]));
            check("alm_min_en", int'(alm_min_en), int'(m_en[4]));
            check("updown", int'(updown), int'(m_up));
            check("sec_clr", int'(sec_clr), int'(m_clr));
        end
    end

    // Drive one clock's worth of inputs, then return just after the sampling edge.
    task automatic step(input logic t, input logic m, input logic u, input logic d,
                        input logic [5:0] s, input logic [5:0] mi);
        @(negedge clk);
        tick_1hz = t; btn_mode = m; btn_up = u; btn_down = d;
        sec_count = s; min_count = mi;
        @(posedge clk);
        #1;
        tick_1hz = 0; btn_mode = 0; btn_up = 0; btn_down = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        cmp_on = 1'b1;
        check("reset_mode", int'(mode), 0);
        check("reset_updown", int'(updown), 1);
        check("reset_ens", int'({sec_en, min_en, hr_en, alm_min_en, alm_hr_en, sec_clr}), 0);

        step(1, 0, 0, 0, 6'd59, 6'd59);
        check("carry_all", int'({sec_en, min_en, hr_en, updown}), 4'b1111);
        step(0, 0, 0, 0, 6'd0, 6'd0);
        check("carry_one_clk", int'({sec_en, min_en, hr_en}), 0);
        step(1, 0, 0, 0, 6'd58, 6'd59);
        check("sec58", int'({sec_en, min_en, hr_en}), 3'b100);
        step(1, 0, 0, 0, 6'd59, 6'd12);
        check("sec59_min12", int'({sec_en, min_en, hr_en}), 3'b110);

        step(0, 1, 0, 0, 6'd0, 6'd0);
        check("enter_set_hr", int'(mode), 1);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 1, 6'd59, 6'd59);
            check("hr_down", int'({hr_en, updown}), 2'b10);
            step(1, 0, 0, 0, 6'd59, 6'd59);
            check("frozen_tick", int'({sec_en, hr_en}), 0);
        end

        step(0, 1, 0, 0, 6'd0, 6'd0);
        check("enter_set_min", int'({mode, sec_clr}), {3'd2, 1'b0});
        step(0, 0, 1, 1, 6'd0, 6'd0);
        check("up_and_down", int'({min_en, updown}), 2'b00);
        step(0, 1, 1, 0, 6'd0, 6'd0);
        check("leave_set_min", int'({mode, sec_clr, alm_hr_en}), {3'd3, 1'b1, 1'b0});
        step(0, 0, 0, 0, 6'd0, 6'd0);
        check("sec_clr_one_clk", int'(sec_clr), 0);

        for (int k = 0; k < TMO; k++) step(1, 0, 0, 0, 6'd0, 6'd0);
        check("pre_timeout", int'(mode), 3);
        step(0, 0, 0, 0, 6'd0, 6'd0);
        check("timeout", int'({mode, sec_clr}), TMO_ON ? 0 : {3'd3, 1'b0});

        for (int k = 0; k < 6 && mode != 3'd2; k++) step(0, 1, 0, 0, 6'd0, 6'd0);
        check("reach_set_min", int'(mode), 2);
        step(0, 0, 1, 0, 6'd0, 6'd0);
        check("min_up", int'({min_en, updown}), 2'b11);
        #2 reset = 1'b1;
        #1;
        check("async_reset", int'({mode, sec_en, min_en, hr_en, alm_min_en, alm_hr_en, sec_clr, updown}), 1);
        @(negedge clk);
        #2 reset = 1'b0;
        step(1, 0, 0, 0, 6'd5, 6'd0);
        check("run_resumes", int'({mode, sec_en}), 1);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            tick_1hz  = ($urandom_range(3) == 0);
            btn_mode  = ($urandom_range(11) == 0);
            btn_up    = ($urandom_range(4) == 0);
            btn_down  = ($urandom_range(4) == 0);
            sec_count = ($urandom_range(1) == 0) ? 6'(58 + $urandom_range(1)) : 6'($urandom_range(63));
            min_count = ($urandom_range(1) == 0) ? 6'(58 + $urandom_range(1)) : 6'($urandom_range(63));
        end
        @(negedge clk);
        tick_1hz = 0; btn_mode = 0; btn_up = 0; btn_down = 0;
        @(negedge clk);
        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
